bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single system bus port between `NUM_REQ` cache-side requesters (icache = 0, dcache = 1, ...).
- Handshake per requester: busreq / busgrant / busidle, the same one the icache already drives.
- Round-robin arbitration; the grant is held for one complete bus transaction.
- Muxes the owner's request-side signals onto the bus and routes response-side strobes only to the owner.

Parameters:
- `NUM_REQ`, 2, number of requesters (2..4).
- `BUS_DATA_WIDTH`, 64, bus_req/bus_resp width.
- `BUS_TAG_WIDTH`, 13, bus_reqtag/bus_resptag width.
- `GRANT_TIMEOUT`, 8, cycles a granted requester may stay idle before the grant is revoked.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `rq_busreq`  in  `NUM_REQ`  per-requester bus request
- `rq_busidle`  in  `NUM_REQ`  per-requester idle (1 = no transaction in flight)
- `rq_busgrant`  out  `NUM_REQ`  one-hot-or-zero grant, registered
- `rq_reqcyc`  in  `NUM_REQ`  per-requester bus_reqcyc
- `rq_respack`  in  `NUM_REQ`  per-requester bus_respack
- `rq_req`  in  `NUM_REQ*BUS_DATA_WIDTH`  packed requests, slot i at [i*W +: W]
- `rq_reqtag`  in  `NUM_REQ*BUS_TAG_WIDTH`  packed request tags
- `rq_reqack`  out  `NUM_REQ`  bus_reqack routed to owner only
- `rq_respcyc`  out  `NUM_REQ`  bus_respcyc routed to owner only
- `rq_resp`  out  `BUS_DATA_WIDTH`  bus_resp broadcast
- `rq_resptag`  out  `BUS_TAG_WIDTH`  bus_resptag broadcast
- `bus_reqcyc`  out  1  to bus
- `bus_respack`  out  1  to bus
- `bus_req`  out  `BUS_DATA_WIDTH`  to bus
- `bus_reqtag`  out  `BUS_TAG_WIDTH`  to bus
- `bus_reqack`  in  1  from bus
- `bus_respcyc`  in  1  from bus
- `bus_resp`  in  `BUS_DATA_WIDTH`  from bus
- `bus_resptag`  in  `BUS_TAG_WIDTH`  from bus
- `owner_id`  out  $clog2(`NUM_REQ`)  current owner index, valid when busy=1
- `busy`  out  1  1 while state != ARB_IDLE

Behaviour:
- Reset values:
  - state = ARB_IDLE, rr_ptr = 0, timeout counter = 0.
  - `rq_busgrant` = 0, `owner_id` = 0, `busy` = 0.
  - All bus_* outputs = 0; `rq_reqack` = 0, `rq_respcyc` = 0.
- ARB_IDLE:
  - If any `rq_busreq` is set, pick the first set bit searching from rr_ptr upward, wrapping modulo `NUM_REQ`.
  - Next edge: grant[pick] = 1, owner_id = pick, state -> ARB_GRANTED, counter = 0.
  - Latency: busreq sampled high at edge t -> busgrant high after edge t+1.
- ARB_GRANTED (waiting for the owner to start):
  - Owner `rq_busidle` = 0 -> ARB_OWNED.
  - Otherwise the counter increments. When counter == `GRANT_TIMEOUT`-1 with idle still 1: revoke the grant, rr_ptr = owner+1 (wrapping), state -> ARB_IDLE.
- ARB_OWNED:
  - Grant stays high.
  - Owner `rq_busidle` returning to 1 -> ARB_RELEASE.
- ARB_RELEASE:
  - Grant deasserted; rr_ptr = owner+1 (wrapping); state -> ARB_IDLE.
  - Forces a minimum of one dead cycle between owners (bus turnaround).
- Muxing (combinational):
  - In ARB_GRANTED/ARB_OWNED: bus_reqcyc, bus_respack, bus_req and bus_reqtag = owner's slot. Otherwise all 0.
  - `rq_reqack[i]` = bus_reqack & (i == owner) & (state in GRANTED/OWNED); same rule for `rq_respcyc`.
  - Non-owners always see 0 on reqack/respcyc. `rq_resp`/`rq_resptag` are a straight broadcast.
- Invariants:
  - At most one grant bit set.
  - No grant change while in ARB_OWNED, regardless of other requests.
  - busreq deasserting after grant has no effect; release is driven only by idle.
- Simultaneous events:
  - Requests arriving during GRANTED/OWNED/RELEASE are held by the requester and arbitrated in ARB_IDLE.
  - Owner re-requesting in ARB_RELEASE loses to any other pending requester, because rr_ptr has advanced.
- Reset mid-transaction: next edge returns to the reset values above; bus_reqcyc drops immediately.

Decomposition:
- Package `bus_arb_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_GRANTED, ARB_OWNED, ARB_RELEASE}; `BUS_TAG_WIDTH`/`BUS_DATA_WIDTH` defaults; `OWNER_W` function ($clog2 of `NUM_REQ`, min 1).
- One sub-module: `rr_picker` (combinational; inputs req vector and rr_ptr; outputs valid and index).

Test Plan:
- Single requester: rq_busreq = 01 at edge 0 -> grant = 01 after edge 1. Drive idle0 = 0 for 10 cycles with reqcyc0 = 1 and req0 = 64'h1000 -> bus_req = 64'h1000 and bus_reqcyc = 1 throughout. idle0 = 1 -> grant = 00 next edge, busy = 0 one edge later.
- Simultaneous requests: busreq = 11 from reset -> requester 0 is granted first. After its release, requester 1 is granted with no intervening grant to 0, even though busreq0 is still 1.
- Response gating: owner = 1, bus_respcyc = 1 and bus_resp = 64'hDEAD -> rq_respcyc = 10, rq_resp = 64'hDEAD; rq_respcyc[0] is never 1.
- Timeout: grant requester 1, keep idle1 = 1 -> grant revoked exactly 8 cycles after it rose; busy = 0. Pending requester 0 is then granted.
- Hold under contention: owner 0 in ARB_OWNED, busreq1 pulses for 20 cycles -> grant stays 01 throughout.
- Reset mid-OWNED: assert reset for one edge -> grant = 0, bus_reqcyc = 0, state ARB_IDLE, rr_ptr = 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and sizing helpers for the system bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANTED,
      ARB_OWNED,
      ARB_RELEASE
   } arb_state_t;

   localparam int DEF_BUS_DATA_WIDTH = 64;
   localparam int DEF_BUS_TAG_WIDTH  = 13;

   function automatic int OWNER_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search for the first set request at or after ptr.
module rr_picker
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int OW = OWNER_W(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [OW-1:0]      ptr,
   output logic               valid,
   output logic [OW-1:0]      index
);

   logic [OW-1:0] cand [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
      assign cand[k] = OW'((int'(ptr) + k) % NUM_REQ);
   end

   assign valid = |req;

   // Walk candidates from farthest to nearest so the nearest set bit wins.
   always_comb begin
      index = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req[cand[k]]) index = cand[k];
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the single system bus port, holding each grant for one
// complete transaction and routing request/response strobes to the owner only.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
   parameter int BUS_TAG_WIDTH  = DEF_BUS_TAG_WIDTH,
   parameter int GRANT_TIMEOUT  = 8,
   localparam int OW = OWNER_W(NUM_REQ)
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  rq_busreq,
   input  logic [NUM_REQ-1:0]                  rq_busidle,
   output logic [NUM_REQ-1:0]                  rq_busgrant,
   input  logic [NUM_REQ-1:0]                  rq_reqcyc,
   input  logic [NUM_REQ-1:0]                  rq_respack,
   input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0]   rq_req,
   input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]    rq_reqtag,
   output logic [NUM_REQ-1:0]                  rq_reqack,
   output logic [NUM_REQ-1:0]                  rq_respcyc,
   output logic [BUS_DATA_WIDTH-1:0]           rq_resp,
   output logic [BUS_TAG_WIDTH-1:0]            rq_resptag,
   output logic                                bus_reqcyc,
   output logic                                bus_respack,
   output logic [BUS_DATA_WIDTH-1:0]           bus_req,
   output logic [BUS_TAG_WIDTH-1:0]            bus_reqtag,
   input  logic                                bus_reqack,
   input  logic                                bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]           bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]            bus_resptag,
   output logic [OW-1:0]                       owner_id,
   output logic                                busy
);

   localparam int CW = $clog2(GRANT_TIMEOUT + 1);

   arb_state_t          state, state_n;
   logic [NUM_REQ-1:0]  grant_n;
   logic [OW-1:0]       owner_n, rr_ptr, rr_ptr_n, pick_idx, next_ptr;
   logic [CW-1:0]       cnt, cnt_n;
   logic                pick_valid, owner_idle, active;
   logic [NUM_REQ-1:0]  owner_oh;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req   (rq_busreq),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .index (pick_idx)
   );

   assign owner_idle = rq_busidle[owner_id];
   assign owner_oh   = NUM_REQ'(1) << owner_id;
   assign next_ptr   = (owner_id == OW'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB_IDLE;
         rq_busgrant <= '0;
         owner_id    <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         rq_busgrant <= grant_n;
         owner_id    <= owner_n;
         rr_ptr      <= rr_ptr_n;
         cnt         <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      grant_n  = rq_busgrant;
      owner_n  = owner_id;
      rr_ptr_n = rr_ptr;
      cnt_n    = cnt;
      case (state)
         ARB_IDLE:
            if (pick_valid) begin
               state_n = ARB_GRANTED;
               grant_n = NUM_REQ'(1) << pick_idx;
               owner_n = pick_idx;
               cnt_n   = '0;
            end
         // An owner that never starts loses the grant so others are not starved.
         ARB_GRANTED:
            if (!owner_idle) state_n = ARB_OWNED;
            else if (cnt == CW'(GRANT_TIMEOUT - 1)) begin
               state_n  = ARB_IDLE;
               grant_n  = '0;
               rr_ptr_n = next_ptr;
            end else cnt_n = cnt + 1'b1;
         ARB_OWNED:
            if (owner_idle) begin
               state_n = ARB_RELEASE;
               grant_n = '0;
            end
         ARB_RELEASE: begin
            state_n  = ARB_IDLE;
            rr_ptr_n = next_ptr;
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   // Reset gates the bus side at once so a cut-off transaction never leaks a cycle.
   assign active      = !reset && (state == ARB_GRANTED || state == ARB_OWNED);
   assign busy        = state != ARB_IDLE;
   assign bus_reqcyc  = active && rq_reqcyc[owner_id];
   assign bus_respack = active && rq_respack[owner_id];
   assign bus_req     = active ? rq_req[owner_id*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;
   assign bus_reqtag  = active ? rq_reqtag[owner_id*BUS_TAG_WIDTH +: BUS_TAG_WIDTH] : '0;
   assign rq_reqack   = (active && bus_reqack) ? owner_oh : '0;
   assign rq_respcyc  = (active && bus_respcyc) ? owner_oh : '0;
   assign rq_resp     = bus_resp;
   assign rq_resptag  = bus_resptag;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plus random stimulus against a transaction-level ownership model.
module tb_bus_arbiter;
   localparam int N  = 2;
   localparam int DW = 64;
   localparam int TW = 13;
   localparam int TO = 8;

   logic clk, reset;
   logic [N-1:0] rq_busreq, rq_busidle, rq_busgrant, rq_reqcyc, rq_respack, rq_reqack, rq_respcyc;
   logic [N*DW-1:0] rq_req;
   logic [N*TW-1:0] rq_reqtag;
   logic [DW-1:0] rq_resp, bus_req, bus_resp;
   logic [TW-1:0] rq_resptag, bus_reqtag, bus_resptag;
   logic bus_reqcyc, bus_respack, bus_reqack, bus_respcyc, busy;
   logic [0:0] owner_id;

   int checks = 0, failures = 0;
   int m_gnt = -1, m_owner = 0, m_ptr = 0, m_cnt = 0;
   bit m_started = 0, m_release = 0;

   bus_arbiter #(.NUM_REQ(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .GRANT_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .rq_busreq(rq_busreq), .rq_busidle(rq_busidle),
      .rq_busgrant(rq_busgrant), .rq_reqcyc(rq_reqcyc), .rq_respack(rq_respack),
      .rq_req(rq_req), .rq_reqtag(rq_reqtag), .rq_reqack(rq_reqack), .rq_respcyc(rq_respcyc),
      .rq_resp(rq_resp), .rq_resptag(rq_resptag), .bus_reqcyc(bus_reqcyc),
      .bus_respack(bus_respack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
      .bus_resptag(bus_resptag), .owner_id(owner_id), .busy(busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Ownership model: who holds the bus, whether they started, idle cycles since grant.
   task automatic model_edge();
      bit found;
      if (reset) begin
         m_gnt = -1; m_owner = 0; m_ptr = 0; m_cnt = 0; m_started = 0; m_release = 0;
      end else if (m_release) begin
         m_release = 0;
         m_ptr = (m_owner + 1) % N;
      end else if (m_gnt < 0) begin
         found = 0;
         for (int k = 0; k < N; k++)
            if (!found && rq_busreq[(m_ptr + k) % N]) begin
               found = 1; m_gnt = (m_ptr + k) % N; m_owner = m_gnt; m_started = 0; m_cnt = 0;
            end
      end else if (!m_started) begin
         if (!rq_busidle[m_gnt]) m_started = 1;
         else begin
            m_cnt++;
            if (m_cnt == TO) begin m_gnt = -1; m_ptr = (m_owner + 1) % N; end
         end
      end else if (rq_busidle[m_gnt]) begin
         m_gnt = -1; m_release = 1;
      end
   endtask

   task automatic check_all();
      logic [N-1:0] e;
      bit act, eb;
      e = '0;
      if (m_gnt >= 0) e[m_gnt] = 1'b1;
      eb = (m_gnt >= 0) || m_release;
      act = (m_gnt >= 0) && !reset;
      chk("grant", 64'(rq_busgrant), 64'(e));
      chk("busy", 64'(busy), 64'(eb));
      if (eb) chk("owner_id", 64'(owner_id), 64'(m_owner));
      chk("bus_reqcyc", 64'(bus_reqcyc), act ? 64'(rq_reqcyc[m_gnt]) : 64'd0);
      chk("bus_respack", 64'(bus_respack), act ? 64'(rq_respack[m_gnt]) : 64'd0);
      chk("bus_req", bus_req, act ? rq_req[m_gnt*DW +: DW] : 64'd0);
      chk("bus_reqtag", 64'(bus_reqtag), act ? 64'(rq_reqtag[m_gnt*TW +: TW]) : 64'd0);
      chk("rq_reqack", 64'(rq_reqack), (act && bus_reqack) ? 64'(e) : 64'd0);
      chk("rq_respcyc", 64'(rq_respcyc), (act && bus_respcyc) ? 64'(e) : 64'd0);
      chk("rq_resp", rq_resp, bus_resp);
      chk("rq_resptag", 64'(rq_resptag), 64'(bus_resptag));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   initial begin
      reset = 1; rq_busreq = '0; rq_busidle = '1; rq_reqcyc = '0; rq_respack = '0;
      rq_req = '0; rq_reqtag = '0; bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
      repeat (3) step();
      chk("reset_grant", 64'(rq_busgrant), 64'd0);
      chk("reset_owner", 64'(owner_id), 64'd0);
      // single requester
      rq_busreq = 2'b01;
      step();
      reset = 0;
      step();
      chk("single_grant", 64'(rq_busgrant), 64'h1);
      rq_busreq = 2'b00; rq_busidle = 2'b10; rq_reqcyc = 2'b01; rq_req[0 +: DW] = 64'h1000;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("single_bus_req", bus_req, 64'h1000);
         chk("single_reqcyc", 64'(bus_reqcyc), 64'h1);
      end
      rq_busidle = 2'b11;
      step();
      chk("single_release_grant", 64'(rq_busgrant), 64'h0);
      chk("single_release_busy", 64'(busy), 64'h1);
      step();
      chk("single_idle_busy", 64'(busy), 64'h0);
      // simultaneous requests
      reset = 1; rq_busreq = 2'b11;
      step();
      reset = 0;
      step();
      chk("simul_first", 64'(rq_busgrant), 64'h1);
      rq_busidle = 2'b10;
      step();
      rq_busidle = 2'b11;
      step();
      chk("simul_gap", 64'(rq_busgrant), 64'h0);
      step();
      chk("simul_gap2", 64'(rq_busgrant), 64'h0);
      step();
      chk("simul_second", 64'(rq_busgrant), 64'h2);
      // response gating with owner 1
      rq_busreq = 2'b10; rq_busidle = 2'b01;
      step();
      bus_respcyc = 1; bus_resp = 64'hDEAD; bus_reqack = 1;
      #1;
      chk("resp_gate", 64'(rq_respcyc), 64'h2);
      chk("resp_data", rq_resp, 64'hDEAD);
      chk("reqack_gate", 64'(rq_reqack), 64'h2);
      step();
      bus_respcyc = 0; bus_reqack = 0; rq_busidle = 2'b11;
      step();
      step();
      step();
      chk("to_grant", 64'(rq_busgrant), 64'h2);
      // timeout with requester 0 pending
      rq_busreq = 2'b11;
      for (int k = 1; k < TO; k++) begin
         step();
         chk("to_hold", 64'(rq_busgrant), 64'h2);
      end
      step();
      chk("to_revoke", 64'(rq_busgrant), 64'h0);
      chk("to_busy", 64'(busy), 64'h0);
      step();
      chk("to_next", 64'(rq_busgrant), 64'h1);
      // hold under contention
      rq_busidle = 2'b10; rq_busreq = 2'b00;
      step();
      for (int i = 0; i < 20; i++) begin
         rq_busreq[1] = i[0];
         step();
         chk("hold_grant", 64'(rq_busgrant), 64'h1);
      end
      rq_busidle = 2'b11; rq_busreq = 2'b10;
      repeat (3) step();
      rq_busidle = 2'b01; rq_reqcyc = 2'b11;
      step();
      chk("pre_reset_owner", 64'(rq_busgrant), 64'h2);
      // reset mid-owned, pointer was 0 -> 1 before reset
      reset = 1;
      #1;
      chk("reset_reqcyc_now", 64'(bus_reqcyc), 64'h0);
      step();
      chk("reset_mid_grant", 64'(rq_busgrant), 64'h0);
      reset = 0; rq_busreq = 2'b11; rq_busidle = 2'b11;
      step();
      chk("reset_ptr", 64'(rq_busgrant), 64'h1);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         rq_busreq = N'($urandom);
         for (int r = 0; r < N; r++) rq_busidle[r] = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 15) == 0) rq_busidle = '1;
         rq_reqcyc = N'($urandom); rq_respack = N'($urandom);
         rq_req = {$urandom, $urandom, $urandom, $urandom};
         rq_reqtag = N*TW'($urandom);
         bus_reqack = 1'($urandom); bus_respcyc = 1'($urandom);
         bus_resp = {$urandom, $urandom}; bus_resptag = TW'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
